ifetch_wb_if: RTL

IFETCH_WB_IF -- requirements
Module: ifetch_wb_if

---
 rtl/ifetch_wb_if_pkg.sv | 27 ++
 rtl/ifetch_wb_if.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ifetch_wb_if_pkg.sv
// Shared definitions for the instruction-fetch Wishbone bridge: control levels,
// NOP word, bus widths and FSM state encodings.
package ifetch_wb_if_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic RstDisable  = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int InstAddrBus = 32;
  localparam int RegBus      = 32;
  localparam int StallBus    = 6;

  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic [3:0]        SelAll   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE           = 2'b00,
    BUSY           = 2'b01,
    WAIT_FOR_STALL = 2'b10
  } ifetch_state_t;

  function automatic logic any_stall(input logic [StallBus-1:0] stall);
    return (stall != '0);
  endfunction

endpackage

// File: rtl/ifetch_wb_if.sv
// Instruction-side Wishbone classic master: turns PC-stage fetch requests into
// single read cycles and holds the fetched word while the pipeline is stalled.
//
// state          | meaning
// ---------------+---------------------------------------------------------
// IDLE           | no bus cycle; accepts a fetch when cpu_ce_i=1 and no flush
// BUSY           | cyc/stb asserted, waiting for wb_ack_i
// WAIT_FOR_STALL | word latched in rd_buf, presented until the stall clears
module ifetch_wb_if
  import ifetch_wb_if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  ifetch_state_t           state_q, state_n;
  logic [InstAddrBus-1:0]  adr_q, adr_n;
  logic                    cyc_q, cyc_n;
  logic                    stb_q, stb_n;
  logic [RegBus-1:0]       rd_buf_q, rd_buf_n;

  logic fetch_req;
  assign fetch_req = (cpu_ce_i == ChipEnable) && !flush;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      rd_buf_q <= ZeroWord;
    end else begin
      state_q  <= state_n;
      adr_q    <= adr_n;
      cyc_q    <= cyc_n;
      stb_q    <= stb_n;
      rd_buf_q <= rd_buf_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    adr_n      = adr_q;
    cyc_n      = cyc_q;
    stb_n      = stb_q;
    rd_buf_n   = rd_buf_q;
    stallreq   = 1'b0;
    cpu_data_o = ZeroWord;

    unique case (state_q)
      IDLE: begin
        if (fetch_req) begin
          adr_n    = cpu_addr_i;
          cyc_n    = 1'b1;
          stb_n    = 1'b1;
          state_n  = BUSY;
          stallreq = 1'b1;
        end
      end

      BUSY: begin
        // Flush wins over a coincident ack: the fetched word belongs to a
        // squashed instruction stream.
        if (flush) begin
          cyc_n    = 1'b0;
          stb_n    = 1'b0;
          rd_buf_n = ZeroWord;
          state_n  = IDLE;
        end else if (wb_ack_i) begin
          cyc_n      = 1'b0;
          stb_n      = 1'b0;
          rd_buf_n   = wb_dat_i;
          cpu_data_o = wb_dat_i;
          state_n    = any_stall(stall) ? WAIT_FOR_STALL : IDLE;
        end else begin
          stallreq = 1'b1;
        end
      end

      WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf_q;
        if (flush) begin
          rd_buf_n = ZeroWord;
          state_n  = IDLE;
        end else if (!any_stall(stall)) begin
          state_n = IDLE;
        end
      end

      default: begin
        cyc_n    = 1'b0;
        stb_n    = 1'b0;
        rd_buf_n = ZeroWord;
        state_n  = IDLE;
      end
    endcase
  end

  assign wb_adr_o = adr_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q & cyc_q;
  assign wb_we_o  = 1'b0;
  assign wb_dat_o = ZeroWord;
  assign wb_sel_o = SelAll;

endmodule
